// File: rtl/msu_data_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : msu_data_fifo_if
// Brief    : Fetch request/acknowledge bus between the MSU data engine and
//            HPS-backed memory.
// Revision : 1.0
// ============================================================================
interface msu_data_fifo_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface
`default_nettype wire

// File: rtl/msu_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : msu_data_fifo
// Brief    : MSU-1 data port: seek decode, prefetch FIFO, zero-wait $2001 reads.
// Revision : 1.0
// ============================================================================
module msu_data_fifo #(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_LOG2  = 4,
    parameter int          PRIME_LEVEL = 4,
    parameter logic [15:0] BASE        = 16'h2000
) (
    input  wire                CLK,
    input  wire                RST_N,
    input  wire                ENABLE,
    input  wire                RD_N,
    input  wire                WR_N,
    input  wire         [23:0] ADDR,
    input  wire          [7:0] DIN,
    output logic         [7:0] DOUT,
    output logic               data_busy,
    output logic               underrun,
    output logic  [ADDR_W-1:0] data_addr,
    msu_data_fifo_if.master    mem
);

    localparam int                  c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_PRIME = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
    localparam logic [15:0]         c_OFF0  = BASE;
    localparam logic [15:0]         c_OFF1  = BASE + 16'd1;
    localparam logic [15:0]         c_OFF2  = BASE + 16'd2;
    localparam logic [15:0]         c_OFF3  = BASE + 16'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_rd_n_1;
    logic                  r_wr_n_1;
    logic [23:0]           r_seek;
    logic [ADDR_W-1:0]     r_fetch_addr;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic                  r_stale;
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  w_sel;
    logic                  w_wr_fall;
    logic                  w_rd_fall;
    logic                  w_rd_rise;
    logic                  w_wr_reg;
    logic                  w_seek;
    logic                  w_rd_port;
    logic                  w_avail;
    logic                  w_ack;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start;
    logic [DEPTH_LOG2:0]   w_count_inc;
    logic [ADDR_W-1:0]     w_seek_addr;

    // Banks $00-$3F and $80-$BF mirror the B-bus register window.
    assign w_sel       = ENABLE & ((ADDR[23:16] <= 8'h3F) |
                                   ((ADDR[23:16] >= 8'h80) & (ADDR[23:16] <= 8'hBF)));
    assign w_wr_fall   = r_wr_n_1 & ~WR_N;
    assign w_rd_fall   = r_rd_n_1 & ~RD_N;
    assign w_rd_rise   = ~r_rd_n_1 & RD_N;
    assign w_wr_reg    = w_sel & w_wr_fall;
    assign w_seek      = w_wr_reg & (ADDR[15:0] == c_OFF3);
    assign w_rd_port   = w_sel & (ADDR[15:0] == c_OFF1);
    assign w_avail     = (r_count != '0) & ~data_busy;
    assign w_ack       = (r_state == S_REQ) & mem.mem_ack;
    // An ack coinciding with a seek belongs to the old file position.
    assign w_push      = w_ack & ~r_stale & ~w_seek;
    assign w_pop       = w_rd_port & w_rd_rise & w_avail;
    assign w_count_inc = r_count + 1'b1;
    assign w_seek_addr = ADDR_W'({DIN, r_seek});
    assign w_start     = (r_state == S_IDLE) & (w_state_next == S_REQ);

    assign mem.mem_req  = (r_state == S_REQ);
    assign mem.mem_addr = r_mem_addr;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Holding off on the seek edge lets the new address take effect first.
                if (!r_count[DEPTH_LOG2] && !r_stale && !w_seek) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_n_1     <= 1'b1;
            r_wr_n_1     <= 1'b1;
            r_seek       <= '0;
            r_fetch_addr <= '0;
            r_mem_addr   <= '0;
            r_stale      <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            DOUT         <= 8'h00;
            data_busy    <= 1'b0;
            underrun     <= 1'b0;
            data_addr    <= '0;
        end else begin
            r_rd_n_1 <= RD_N;
            r_wr_n_1 <= WR_N;
            underrun <= 1'b0;

            if (w_wr_reg) begin
                if (ADDR[15:0] == c_OFF0) r_seek[7:0]   <= DIN;
                if (ADDR[15:0] == c_OFF1) r_seek[15:8]  <= DIN;
                if (ADDR[15:0] == c_OFF2) r_seek[23:16] <= DIN;
            end

            if (w_rd_port && w_rd_fall) begin
                if (w_avail) begin
                    DOUT <= r_mem[r_rd_ptr];
                end else begin
                    DOUT     <= 8'h00;
                    underrun <= 1'b1;
                end
            end

            if (w_start) begin
                r_mem_addr <= r_fetch_addr;
            end

            if (w_seek) begin
                r_fetch_addr <= w_seek_addr;
                data_addr    <= w_seek_addr;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_count      <= '0;
                data_busy    <= 1'b1;
                r_stale      <= (r_state == S_REQ) & ~mem.mem_ack;
            end else begin
                if (w_ack) begin
                    r_stale <= 1'b0;
                end
                if (w_push) begin
                    r_wr_ptr     <= r_wr_ptr + 1'b1;
                    r_fetch_addr <= r_fetch_addr + 1'b1;
                    // Wrapping past the end of the address space also primes.
                    if ((w_count_inc == c_PRIME) || (&r_fetch_addr)) begin
                        data_busy <= 1'b0;
                    end
                end
                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    data_addr <= data_addr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= w_count_inc;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem.mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msu_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_msu_data_fifo
// Brief    : Queue-based reference model of the MSU data port with directed
//            scenarios and randomized bus traffic.
// Revision : 1.0
// ============================================================================
module tb_msu_data_fifo;

    localparam int PRIME = 4;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        ENABLE = 1'b1;
    logic        RD_N = 1'b1;
    logic        WR_N = 1'b1;
    logic [23:0] ADDR = 24'h0;
    logic [7:0]  DIN = 8'h0;
    logic [7:0]  DOUT;
    logic        data_busy;
    logic        underrun;
    logic [31:0] data_addr;

    msu_data_fifo_if #(.ADDR_W(32)) mif ();

    msu_data_fifo #(
        .ADDR_W(32), .DEPTH_LOG2(4), .PRIME_LEVEL(PRIME), .BASE(16'h2000)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .RD_N(RD_N), .WR_N(WR_N),
        .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .data_busy(data_busy),
        .underrun(underrun), .data_addr(data_addr), .mem(mif)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- memory responder (byte = address LSB) ----------------
    int          lat_fixed = 3;
    bit          force_ack = 1'b0;
    bit          in_req    = 1'b0;
    int          cnt       = 0;
    int          req_count = 0;
    int          ack_count = 0;
    int          und_count = 0;
    logic [31:0] req_addrs[$];

    initial begin
        mif.mem_ack  = 1'b0;
        mif.mem_data = 8'h00;
    end

    always @(negedge CLK) begin
        mif.mem_ack  = 1'b0;
        mif.mem_data = 8'($urandom);
        if (underrun === 1'b1) und_count++;
        if (!RST_N) in_req = 1'b0;
        if (force_ack) begin
            mif.mem_ack  = 1'b1;
            mif.mem_data = 8'hEE;
        end else if (RST_N && mif.mem_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                req_count++;
                req_addrs.push_back(mif.mem_addr);
                cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
            cnt--;
            if (cnt <= 0) begin
                mif.mem_ack  = 1'b1;
                mif.mem_data = mif.mem_addr[7:0];
                in_req       = 1'b0;
                ack_count++;
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    logic [7:0]  m_q[$];
    logic [23:0] m_seek;
    logic [31:0] m_fetch, m_daddr, m_maddr;
    logic [7:0]  m_dout;
    bit          m_busy, m_und, m_req, m_stale, m_rd1, m_wr1;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_q.delete();
            m_seek = 0; m_fetch = 0; m_daddr = 0; m_maddr = 0; m_dout = 0;
            m_busy = 0; m_und = 0; m_req = 0; m_stale = 0; m_rd1 = 1; m_wr1 = 1;
        end else begin
            automatic bit sel = ENABLE && ((ADDR[23:16] <= 8'h3F) ||
                                           (ADDR[23:16] >= 8'h80 && ADDR[23:16] <= 8'hBF));
            automatic bit wfall = m_wr1 && !WR_N;
            automatic bit rfall = m_rd1 && !RD_N;
            automatic bit rrise = !m_rd1 && RD_N;
            automatic bit port  = sel && (ADDR[15:0] == 16'h2001);
            automatic bit seek  = sel && wfall && (ADDR[15:0] == 16'h2003);
            automatic bit ack   = m_req && mif.mem_ack;
            automatic bit avail = (m_q.size() != 0) && !m_busy;
            automatic int n_pre = m_q.size();
            automatic logic [31:0] fetch_pre = m_fetch;
            m_und = 0;
            if (port && rfall) begin
                if (avail) m_dout = m_q[0];
                else begin m_dout = 8'h00; m_und = 1; end
            end
            if (sel && wfall) begin
                if (ADDR[15:0] == 16'h2000) m_seek[7:0]   = DIN;
                if (ADDR[15:0] == 16'h2001) m_seek[15:8]  = DIN;
                if (ADDR[15:0] == 16'h2002) m_seek[23:16] = DIN;
            end
            if (seek) begin
                m_fetch = {DIN, m_seek};
                m_daddr = {DIN, m_seek};
                m_q.delete();
                m_busy  = 1;
                m_stale = m_req && !ack;
                m_req   = m_req && !ack;
            end else begin
                if (port && rrise && avail) begin
                    void'(m_q.pop_front());
                    m_daddr++;
                end
                if (ack) begin
                    if (!m_stale) begin
                        m_q.push_back(mif.mem_data);
                        if (m_busy && (m_q.size() == PRIME || fetch_pre == 32'hFFFF_FFFF)) m_busy = 0;
                        m_fetch++;
                    end
                    m_stale = 0;
                    m_req   = 0;
                end else if (!m_req && n_pre < DEPTH && !m_stale) begin
                    m_req   = 1;
                    m_maddr = fetch_pre;
                end
            end
            m_rd1 = RD_N;
            m_wr1 = WR_N;
        end
    end

    always @(negedge CLK) begin
        chk("DOUT",      {24'h0, DOUT},        {24'h0, m_dout});
        chk("data_busy", {31'h0, data_busy},   {31'h0, m_busy});
        chk("underrun",  {31'h0, underrun},    {31'h0, m_und});
        chk("data_addr", data_addr,            m_daddr);
        chk("mem_req",   {31'h0, mif.mem_req}, {31'h0, m_req});
        chk("mem_addr",  mif.mem_addr,         m_maddr);
    end

    // ---------------- bus tasks ----------------
    logic [7:0] bank = 8'h00;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge CLK);
        ADDR = {bank, a}; DIN = d; WR_N = 1'b0;
        @(negedge CLK);
        WR_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic seek_to(input logic [31:0] a);
        bus_write(16'h2000, a[7:0]);
        bus_write(16'h2001, a[15:8]);
        bus_write(16'h2002, a[23:16]);
        bus_write(16'h2003, a[31:24]);
    endtask

    task automatic bus_read(input logic [15:0] a, input int hold,
                            output logic [7:0] d, output logic und);
        @(negedge CLK);
        ADDR = {bank, a}; RD_N = 1'b0;
        @(negedge CLK);
        d = DOUT; und = underrun;
        repeat (hold - 1) @(negedge CLK);
        RD_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_not_busy(input int budget, input string nm);
        int i = 0;
        while (data_busy !== 1'b0 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        chk(nm, {31'h0, data_busy}, 32'h0);
    endtask

    task automatic wait_req(input int budget, input string nm);
        int i = 0;
        while (mif.mem_req !== 1'b1 && i < budget) begin
            @(negedge CLK);
            i++;
        end
        chk(nm, {31'h0, mif.mem_req}, 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       u;
        int         a0, r0, u0;

        #1 RST_N = 1'b0;
        tick(3);
        chk("reset DOUT",      {24'h0, DOUT}, 32'h0);
        chk("reset busy",      {31'h0, data_busy}, 32'h0);
        chk("reset underrun",  {31'h0, underrun}, 32'h0);
        chk("reset data_addr", data_addr, 32'h0);
        chk("reset mem_req",   {31'h0, mif.mem_req}, 32'h0);
        chk("reset mem_addr",  mif.mem_addr, 32'h0);
        RST_N = 1'b1;

        // Seek 0x100, latency 3: prime after 4 pushes, bytes 00..07.
        lat_fixed = 3;
        tick(100);
        a0 = ack_count;
        seek_to(32'h0000_0100);
        chk("T1 busy after seek", {31'h0, data_busy}, 32'h1);
        wait_not_busy(100, "T1 busy clears");
        chk("T1 pushes at prime", ack_count - a0, 32'd4);
        tick(60);
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h2001, 1, d, u);
            chk($sformatf("T1 read %0d", i), {24'h0, d}, i);
        end
        chk("T1 data_addr", data_addr, 32'h108);

        // Fill with no reads: 16 requests then silence; one read adds one.
        tick(100);
        r0 = req_count;
        seek_to(32'h0000_0200);
        tick(150);
        chk("T2 requests to full", req_count - r0, 32'd16);
        chk("T2 idle when full", {31'h0, mif.mem_req}, 32'h0);
        bus_read(16'h2001, 1, d, u);
        chk("T2 read byte", {24'h0, d}, 32'h00);
        tick(40);
        chk("T2 one refill request", req_count - r0, 32'd17);

        // Seek during an outstanding request: stale byte dropped.
        lat_fixed = 20;
        seek_to(32'h0000_0010);
        wait_req(10, "T3 request issued");
        seek_to(32'h0000_0080);
        wait_not_busy(300, "T3 busy clears");
        bus_read(16'h2001, 1, d, u);
        chk("T3 first read", {24'h0, d}, 32'h80);

        // Read while busy right after a seek.
        lat_fixed = 3;
        tick(150);
        u0 = und_count;
        seek_to(32'h0000_0300);
        bus_read(16'h2001, 1, d, u);
        chk("T4 DOUT", {24'h0, d}, 32'h00);
        chk("T4 underrun", {31'h0, u}, 32'h1);
        tick(3);
        chk("T4 underrun pulses", und_count - u0, 32'd1);
        chk("T4 data_addr", data_addr, 32'h300);

        // Address wrap primes early.
        lat_fixed = 2;
        tick(120);
        req_addrs.delete();
        a0 = ack_count;
        seek_to(32'hFFFF_FFFE);
        wait_not_busy(60, "T5 busy clears");
        chk("T5 pushes at wrap", ack_count - a0, 32'd2);
        tick(20);
        chk("T5 fetch 0", req_addrs[0], 32'hFFFF_FFFE);
        chk("T5 fetch 1", req_addrs[1], 32'hFFFF_FFFF);
        chk("T5 fetch 2", req_addrs[2], 32'h0000_0000);
        bus_read(16'h2001, 1, d, u);
        chk("T5 read FE", {24'h0, d}, 32'hFE);
        bus_read(16'h2001, 1, d, u);
        chk("T5 read FF", {24'h0, d}, 32'hFF);
        chk("T5 data_addr wrap", data_addr, 32'h0);

        // Reset mid-request; late ack must not push.
        lat_fixed = 30;
        tick(200);
        seek_to(32'h0000_0040);
        wait_req(10, "T6 request issued");
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("T6 DOUT",      {24'h0, DOUT}, 32'h0);
        chk("T6 busy",      {31'h0, data_busy}, 32'h0);
        chk("T6 underrun",  {31'h0, underrun}, 32'h0);
        chk("T6 data_addr", data_addr, 32'h0);
        chk("T6 mem_req",   {31'h0, mif.mem_req}, 32'h0);
        chk("T6 mem_addr",  mif.mem_addr, 32'h0);
        @(posedge CLK); #1 force_ack = 1'b1;
        @(posedge CLK); #1 force_ack = 1'b0;
        @(posedge CLK); #2 RST_N = 1'b1;
        bus_read(16'h2001, 1, d, u);
        chk("T6 no late push", {24'h0, d}, 32'h00);
        chk("T6 empty underrun", {31'h0, u}, 32'h1);

        // Randomized traffic.
        lat_fixed = 0;
        for (int n = 0; n < 300; n++) begin
            automatic int op = $urandom_range(0, 9);
            automatic int bsel = $urandom_range(0, 9);
            bank   = (bsel < 7) ? 8'($urandom_range(0, 3) * 8'h40 + ((bsel & 1) ? 8'h3F : 8'h00)) & 8'hBF
                                : 8'($urandom_range(0, 1) ? 8'h40 : 8'hC5);
            ENABLE = ($urandom_range(0, 15) != 0);
            case (op)
                0, 1: begin
                    automatic logic [31:0] sa = ($urandom_range(0, 4) == 0)
                                                ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
                    seek_to(sa);
                end
                2, 3, 4, 5: bus_read(16'h2001, $urandom_range(1, 3), d, u);
                6: bus_write(16'h2000 + 16'($urandom_range(0, 7)), 8'($urandom));
                7: bus_read(16'h2000 + 16'($urandom_range(0, 7)), 1, d, u);
                default: tick($urandom_range(0, 8));
            endcase
        end
        bank   = 8'h00;
        ENABLE = 1'b1;
        tick(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
